// File: rtl/load_align_unit.sv
// ============================================================================
// Module   : load_align_unit
// Purpose  : Multi-cycle load unit: one word read per load, then byte/half
//            lane alignment with sign/zero extension for writeback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ld_start,
   input  logic [31:0] ld_addr,
   input  logic [2:0]  ld_funct3,
   input  logic        flush,
   output logic        ld_busy,
   output logic        ld_done,
   output logic        ld_err,
   output logic [31:0] ld_data,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT - 1);

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic [1:0]  off_q;
   logic [2:0]  f3_q;
   logic        mem_req_q;
   logic        ld_done_q;
   logic        ld_err_q;
   logic [31:0] ld_data_q;
   logic [31:0] mem_addr_q;

   function automatic logic is_legal(input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         3'b000, 3'b100: is_legal = 1'b1;
         3'b001, 3'b101: is_legal = ~a[0];
         3'b010:         is_legal = (a == 2'b00);
         default:        is_legal = 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] extract(input logic [2:0]  f3,
                                           input logic [1:0]  a,
                                           input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      case (a)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = a[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  extract = {{24{b[7]}}, b};
         3'b100:  extract = {24'd0, b};
         3'b001:  extract = {{16{h[15]}}, h};
         3'b101:  extract = {16'd0, h};
         default: extract = w;
      endcase
   endfunction

   // Result and done pulse are registered on the REQ->RESP edge so both are
   // visible throughout the single RESP cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= 8'd0;
         off_q      <= 2'd0;
         f3_q       <= 3'd0;
         mem_req_q  <= 1'b0;
         ld_done_q  <= 1'b0;
         ld_err_q   <= 1'b0;
         ld_data_q  <= 32'd0;
         mem_addr_q <= 32'd0;
      end else begin
         ld_done_q <= 1'b0;
         ld_err_q  <= 1'b0;
         if (flush) begin
            state_q   <= S_IDLE;
            mem_req_q <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (ld_start) begin
                     off_q      <= ld_addr[1:0];
                     f3_q       <= ld_funct3;
                     mem_addr_q <= {ld_addr[31:2], 2'b00};
                     if (is_legal(ld_funct3, ld_addr[1:0])) begin
                        state_q   <= S_REQ;
                        mem_req_q <= 1'b1;
                        cnt_q     <= 8'd0;
                     end else begin
                        ld_err_q <= 1'b1;
                     end
                  end
               end
               S_REQ: begin
                  if (mem_ready) begin
                     ld_data_q <= extract(f3_q, off_q, mem_rdata);
                     ld_done_q <= 1'b1;
                     mem_req_q <= 1'b0;
                     state_q   <= S_RESP;
                  end else if (cnt_q == C_TO_LAST) begin
                     ld_err_q  <= 1'b1;
                     mem_req_q <= 1'b0;
                     state_q   <= S_IDLE;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
               S_RESP: begin
                  state_q <= S_IDLE;
               end
               default: begin
                  state_q   <= S_IDLE;
                  mem_req_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign ld_busy  = (state_q != S_IDLE);
   assign ld_done  = ld_done_q;
   assign ld_err   = ld_err_q;
   assign ld_data  = ld_data_q;
   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_load_align_unit.sv
// ============================================================================
// Module   : tb_load_align_unit
// Purpose  : Directed and randomized bench for load_align_unit with a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_align_unit;

   localparam int unsigned C_TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ld_start = 1'b0;
   logic [31:0] ld_addr = 32'd0;
   logic [2:0]  ld_funct3 = 3'd0;
   logic        flush = 1'b0;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        ld_busy;
   logic        ld_done;
   logic        ld_err;
   logic [31:0] ld_data;
   logic        mem_req;
   logic [31:0] mem_addr;

   int          total = 0;
   int          bad = 0;
   logic [31:0] model_data = 32'd0;

   load_align_unit #(.TIMEOUT(C_TO)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld_start  (ld_start),
      .ld_addr   (ld_addr),
      .ld_funct3 (ld_funct3),
      .flush     (flush),
      .ld_busy   (ld_busy),
      .ld_done   (ld_done),
      .ld_err    (ld_err),
      .ld_data   (ld_data),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit ref_legal(input int f3, input logic [31:0] addr);
      case (f3)
         0, 4:    return 1'b1;
         1, 5:    return (addr % 2) == 0;
         2:       return (addr % 4) == 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] ref_extract(input int f3, input logic [31:0] addr,
                                               input logic [31:0] w);
      logic [31:0] v;
      case (f3)
         0, 4: begin
            v = (w >> (8 * (addr % 4))) & 32'hFF;
            if (f3 == 0 && v >= 128) v = v - 256;
         end
         1, 5: begin
            v = (w >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
            if (f3 == 1 && v >= 32768) v = v - 65536;
         end
         default: v = w;
      endcase
      return v;
   endfunction

   // One load from IDLE; called at a negedge, returns at a negedge with the
   // unit back in IDLE.
   task automatic do_load(input int f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input int wait_n);
      int nreq;
      ld_start  = 1'b1;
      ld_addr   = addr;
      ld_funct3 = 3'(f3);
      @(negedge clk);
      ld_start = 1'b0;
      ld_addr  = $urandom;
      if (!ref_legal(f3, addr)) begin
         check("ill_err_pulse", ld_err, 1);
         check("ill_no_req", mem_req, 0);
         check("ill_busy", ld_busy, 0);
         check("ill_data_kept", ld_data, model_data);
         @(negedge clk);
         check("ill_err_once", ld_err, 0);
         check("ill_no_req2", mem_req, 0);
         return;
      end
      nreq = (wait_n < int'(C_TO)) ? wait_n + 1 : int'(C_TO);
      for (int k = 0; k < nreq; k++) begin
         check("req_high", mem_req, 1);
         check("req_busy", ld_busy, 1);
         check("req_addr", mem_addr, addr & 32'hFFFF_FFFC);
         check("req_no_done", ld_done, 0);
         if (k == wait_n) begin
            mem_ready = 1'b1;
            mem_rdata = rdata;
         end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
         end
         @(negedge clk);
      end
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (wait_n < int'(C_TO)) begin
         model_data = ref_extract(f3, addr, rdata);
         check("resp_done", ld_done, 1);
         check("resp_data", ld_data, model_data);
         check("resp_req_low", mem_req, 0);
         check("resp_no_err", ld_err, 0);
         @(negedge clk);
         check("done_once", ld_done, 0);
         check("idle_busy", ld_busy, 0);
         check("idle_data_kept", ld_data, model_data);
      end else begin
         check("to_err", ld_err, 1);
         check("to_busy", ld_busy, 0);
         check("to_req_low", mem_req, 0);
         check("to_no_done", ld_done, 0);
         check("to_data_kept", ld_data, model_data);
         @(negedge clk);
         check("to_err_once", ld_err, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset values
      @(negedge clk);
      check("rst_busy", ld_busy, 0);
      check("rst_done", ld_done, 0);
      check("rst_err", ld_err, 0);
      check("rst_req", mem_req, 0);
      check("rst_data", ld_data, 0);
      check("rst_addr", mem_addr, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // directed loads
      do_load(2, 32'h100, 32'hDEADBEEF, 0);
      do_load(0, 32'h103, 32'h80FF0000, 0);
      do_load(4, 32'h103, 32'h80FF0000, 1);
      do_load(1, 32'h102, 32'h80FF0000, 2);
      do_load(5, 32'h102, 32'h80FF0000, 0);
      do_load(2, 32'h102, 32'h12345678, 0);
      do_load(3, 32'h100, 32'h12345678, 0);
      do_load(1, 32'h101, 32'h12345678, 0);
      do_load(2, 32'h200, 32'h12345678, 10);
      do_load(0, 32'h204, 32'h0000007F, 3);

      // mem_ready while idle is ignored
      mem_ready = 1'b1;
      mem_rdata = 32'hA5A5A5A5;
      @(negedge clk);
      mem_ready = 1'b0;
      check("idle_ready_busy", ld_busy, 0);
      check("idle_ready_done", ld_done, 0);
      check("idle_ready_data", ld_data, model_data);

      // flush on second REQ cycle together with mem_ready
      ld_start = 1'b1; ld_addr = 32'h300; ld_funct3 = 3'd2;
      @(negedge clk);
      ld_start = 1'b0;
      check("fl_req1", mem_req, 1);
      @(negedge clk);
      check("fl_req2", mem_req, 1);
      flush = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      flush = 1'b0; mem_ready = 1'b0;
      check("fl_busy", ld_busy, 0);
      check("fl_req_low", mem_req, 0);
      check("fl_no_done", ld_done, 0);
      check("fl_no_err", ld_err, 0);
      check("fl_data_kept", ld_data, model_data);
      @(negedge clk);
      check("fl_no_done2", ld_done, 0);

      // ld_start while busy is ignored
      ld_start = 1'b1; ld_addr = 32'h400; ld_funct3 = 3'd2;
      @(negedge clk);
      ld_addr = 32'h504;
      check("bz_req", mem_req, 1);
      @(negedge clk);
      ld_start = 1'b0;
      check("bz_addr", mem_addr, 32'h400);
      mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
      @(negedge clk);
      mem_ready = 1'b0;
      model_data = 32'h0BADF00D;
      check("bz_done", ld_done, 1);
      check("bz_data", ld_data, model_data);
      @(negedge clk);
      check("bz_no_second_req", mem_req, 0);
      check("bz_idle", ld_busy, 0);
      @(negedge clk);
      check("bz_no_second_req2", mem_req, 0);

      // reset mid-load
      ld_start = 1'b1; ld_addr = 32'h600; ld_funct3 = 3'd2;
      @(negedge clk);
      ld_start = 1'b0;
      check("rm_req", mem_req, 1);
      #1 rst_n = 1'b0;
      #1;
      model_data = 32'd0;
      check("rm_busy", ld_busy, 0);
      check("rm_req_low", mem_req, 0);
      check("rm_addr", mem_addr, 0);
      check("rm_data", ld_data, 0);
      check("rm_done", ld_done, 0);
      check("rm_err", ld_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      mem_ready = 1'b1; mem_rdata = 32'h11112222;
      @(negedge clk);
      mem_ready = 1'b0;
      check("rm_late_ready_done", ld_done, 0);
      check("rm_late_ready_data", ld_data, 0);

      // randomized loads
      for (int i = 0; i < 60; i++) begin
         do_load(int'($urandom_range(0, 7)), $urandom, $urandom,
                 int'($urandom_range(0, 5)));
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
